// File: rtl/program_counter_pkg.sv
// Shared CPU constants for the program counter and the instruction-memory address path,
// plus the control decode used by the counter's next-state logic.
package program_counter_pkg;

  localparam int unsigned PC_WIDTH        = 32'd8;
  localparam int unsigned PC_RESET_VAL    = 32'd0;
  localparam int unsigned PC_STEP         = 32'd1;
  localparam int unsigned IMEM_ADDR_WIDTH = PC_WIDTH;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_LOAD = 2'b01,
    PC_INC  = 2'b10,
    PC_DEC  = 2'b11
  } pc_op_e;

  // Load beats count, count beats hold; direction only matters while counting.
  function automatic pc_op_e pc_decode(input logic ld, input logic ens, input logic up);
    pc_op_e op;
    if (ld) begin
      op = PC_LOAD;
    end else if (ens) begin
      if (up) begin
        op = PC_INC;
      end else begin
        op = PC_DEC;
      end
    end else begin
      op = PC_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Loadable up/down program counter: one register plus a separate next-state process.
// Wraps silently modulo 2^WIDTH; rst is asynchronous and active-low.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH,
  parameter int unsigned RESET_VAL = PC_RESET_VAL,
  parameter int unsigned STEP      = PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_ld,
  input  logic             pc_ens,
  input  logic             pc_up,
  output logic [WIDTH-1:0] pc_out
);

  // Truncation to WIDTH makes STEP and RESET_VAL act modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  pc_op_e           op_s;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] pc_r;

  // Next-state selection from the decoded control priority.
  always_comb begin
    op_s      = pc_decode(pc_ld, pc_ens, pc_up);
    pc_next_s = pc_r;
    case (op_s)
      PC_LOAD: pc_next_s = pc_in;
      PC_INC:  pc_next_s = pc_r + STEP_W;
      PC_DEC:  pc_next_s = pc_r - STEP_W;
      PC_HOLD: pc_next_s = pc_r;
      default: pc_next_s = pc_r;
    endcase
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= RESET_W;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc_out = pc_r;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a default instance (step 1, reset 0x00) and one with
// STEP=259 (acts as 3) and RESET_VAL=0x10, both driven by the same directed stimulus.
module tb_program_counter;

  typedef struct {
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    string      name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] pc_in;
  logic       pc_ld;
  logic       pc_ens;
  logic       pc_up;
  logic [7:0] out_a;
  logic [7:0] out_b;

  exp_t exp_q[$];
  int   total;
  int   bad;

  program_counter dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_ld(pc_ld),
    .pc_ens(pc_ens), .pc_up(pc_up), .pc_out(out_a)
  );

  program_counter #(.WIDTH(8), .RESET_VAL(32'd16), .STEP(32'd259)) dut_step (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_ld(pc_ld),
    .pc_ens(pc_ens), .pc_up(pc_up), .pc_out(out_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: the outputs move on a rising clk or a falling rst; compare one entry per event.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total = total + 1;
        if (out_a !== e.exp_a) begin
          bad = bad + 1;
          $display("FAIL %s step1: got %h expected %h", e.name, out_a, e.exp_a);
        end
        total = total + 1;
        if (out_b !== e.exp_b) begin
          bad = bad + 1;
          $display("FAIL %s step3: got %h expected %h", e.name, out_b, e.exp_b);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive controls at the falling edge; the expectation is for the following rising edge.
  task automatic step(input logic r, input logic ld, input logic ens, input logic up,
                      input logic [7:0] din, input logic [7:0] ea, input logic [7:0] eb,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst    = r;
    pc_ld  = ld;
    pc_ens = ens;
    pc_up  = up;
    pc_in  = din;
    e.exp_a = ea;
    e.exp_b = eb;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  // Pull rst low in the middle of a clock period and expect the reset value at once.
  task automatic async_reset(input string nm);
    exp_t e;
    @(negedge clk);
    #2;
    e.exp_a = 8'h00;
    e.exp_b = 8'h10;
    e.name  = nm;
    exp_q.push_back(e);
    rst = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    pc_ld  = 1'b1;
    pc_ens = 1'b0;
    pc_up  = 1'b1;
    pc_in  = 8'hAA;

    // Reset held with a pending load
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, 8'h10, "reset_hold0");
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 8'h10, "reset_hold1");

    // Count up from reset
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h01, 8'h13, "up1");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h02, 8'h16, "up2");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h03, 8'h19, "up3");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h04, 8'h1C, "up4");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'h05, 8'h1F, "up5");

    // Load beats count
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hAA, 8'hAA, "load1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 8'hAA, 8'hAA, "load2");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'hAB, 8'hAD, "after_load1");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 8'hAC, 8'hB0, "after_load2");

    // Count down, then hold with the direction toggling
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'hAB, 8'hAD, "down1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'hAA, 8'hAA, "down2");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 8'hA9, 8'hA7, "down3");
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 8'hA9, 8'hA7, "hold1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'hA9, 8'hA7, "hold2");
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 8'hA9, 8'hA7, "hold3");

    // Wrap both directions
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, "load_ff");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h02, "wrap_up");
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, "load_00");
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFD, "wrap_down");

    // Reset in the middle of counting
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h36, 8'h36, 8'h36, "load_36");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h36, 8'h37, 8'h39, "up_37");
    async_reset("async_rst");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h36, 8'h00, 8'h10, "rst_held");
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h36, 8'h01, 8'h13, "resume");

    // Abort a load with reset
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h5A, 8'h5A, "load_5a");
    async_reset("async_rst_load");
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 8'h10, "post_rst_hold");

    @(negedge clk);
    @(negedge clk);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of the counter, load data and output.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, meaning the value pc_out takes while reset is asserted.
REQ-003 The block SHALL have parameter STEP, default 1, meaning the increment/decrement amount per enabled cycle.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port pc_in  input  WIDTH  meaning the parallel load value.
REQ-007 The block SHALL have port pc_ld  input  1  meaning the synchronous load strobe.
REQ-008 The block SHALL have port pc_ens  input  1  meaning the count enable.
REQ-009 The block SHALL have port pc_up  input  1  meaning the count direction: 1 = up, 0 = down.
REQ-010 The block SHALL have port pc_out  output  WIDTH  meaning the current counter value, driven directly from a register.

Function
REQ-011 The block SHALL evaluate its controls at each rising clk edge while rst is high, in the priority order pc_ld, then pc_ens, then hold.
REQ-012 When pc_ld=1, the block SHALL set pc_out to pc_in on that edge, regardless of pc_ens and pc_up.
REQ-013 When pc_ld=0, pc_ens=1 and pc_up=1, the block SHALL set pc_out to (pc_out + STEP) mod 2^WIDTH.
REQ-014 When pc_ld=0, pc_ens=1 and pc_up=0, the block SHALL set pc_out to (pc_out - STEP) mod 2^WIDTH.
REQ-015 When pc_ld=0 and pc_ens=0, the block SHALL hold pc_out unchanged, whatever the value of pc_up.
REQ-016 The block SHALL wrap silently with no overflow flag: 0xFF counting up gives 0x00, and 0x00 counting down gives 0xFF (WIDTH=8, STEP=1).
REQ-017 pc_out SHALL change only on the clk edge following the control inputs (one-cycle latency) and SHALL NOT depend combinationally on any input.
REQ-018 The block SHALL treat STEP modulo 2^WIDTH.

Reset
REQ-019 The block SHALL set pc_out to RESET_VAL immediately, without waiting for a clk edge, when rst goes low.
REQ-020 While rst is low, the block SHALL ignore pc_ld, pc_ens and pc_up, and pc_out SHALL stay at RESET_VAL.
REQ-021 After rst is released (goes high), the first state change SHALL occur at the next rising clk edge, following REQ-011.
REQ-022 Asserting rst in the middle of a count or a load SHALL abort it, and pc_out SHALL go to RESET_VAL.

Structure
REQ-023 The block SHALL be a single register with next-state logic and no sub-modules.
REQ-024 The default values of WIDTH, RESET_VAL and STEP SHALL be defined as constants in the shared CPU package, so that the instruction-memory address width stays consistent with the counter width.
REQ-025 The next-state computation SHALL be a separate combinational process from the state register.

Verification
REQ-026 Reset scenario: hold rst=0 for 2 cycles with pc_ld=1 and pc_in=0xAA -> pc_out=0x00 throughout; pc_out=0x00 immediately after rst falls in the middle of a clock period.
REQ-027 Count-up scenario: release rst, set pc_ens=1, pc_up=1 for 5 cycles -> pc_out reads 0x01, 0x02, 0x03, 0x04, 0x05.
REQ-028 Load-priority scenario: pc_ld=1, pc_ens=1, pc_in=0xAA for 2 cycles, then pc_ld=0 -> pc_out=0xAA, 0xAA, then 0xAB, 0xAC.
REQ-029 Count-down and hold scenario: from 0xAC set pc_up=0 for 3 cycles -> 0xAB, 0xAA, 0xA9; then pc_ens=0 with pc_up toggling -> pc_out holds 0xA9.
REQ-030 Wrap scenario: load 0xFF then count up -> 0x00; load 0x00 then count down -> 0xFF.
REQ-031 Reset-mid-operation scenario: assert rst=0 while counting at 0x37 -> pc_out=0x00 asynchronously; after release, counting resumes 0x01 at the next edge.
